// File: rtl/datapath_pkg.sv
// Shared types and bus-strobe index constants for the single-bus datapath and its MUL/DIV unit.
package datapath_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_SHR  = 5'd4,
        OP_SHRA = 5'd5,
        OP_SHL  = 5'd6,
        OP_ROR  = 5'd7,
        OP_ROL  = 5'd8,
        OP_NEG  = 5'd9,
        OP_NOT  = 5'd10,
        OP_MUL  = 5'd11,
        OP_DIV  = 5'd12
    } alu_op_t;

    localparam int SIN_HI  = 0;
    localparam int SIN_LO  = 1;
    localparam int SIN_Y   = 2;
    localparam int SIN_Z   = 3;
    localparam int SIN_PC  = 4;
    localparam int SIN_MDR = 5;
    localparam int SIN_MAR = 6;
    localparam int SIN_IR  = 7;

    localparam int SOUT_HI     = 0;
    localparam int SOUT_LO     = 1;
    localparam int SOUT_ZHI    = 2;
    localparam int SOUT_ZLO    = 3;
    localparam int SOUT_PC     = 4;
    localparam int SOUT_MDR    = 5;
    localparam int SOUT_INPORT = 6;
    localparam int SOUT_C      = 7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    function automatic logic is_muldiv(alu_op_t op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/param_bus_datapath_if.sv
// Control strobes from the control unit and observation outputs of the datapath.
interface param_bus_datapath_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) ();
    logic [NUM_REGS-1:0]     rin;
    logic [NUM_REGS-1:0]     rout;
    logic [7:0]              sin;
    logic [7:0]              sout;
    logic                    ba_out;
    logic                    inc_pc;
    logic                    md_read;
    logic [DATA_W-1:0]       mem_data_in;
    logic                    inport_strobe;
    logic [DATA_W-1:0]       inport_data;
    datapath_pkg::alu_op_t   alu_op;
    logic                    op_start;

    logic [DATA_W-1:0]       bus_data;
    logic [DATA_W-1:0]       mar_q;
    logic [DATA_W-1:0]       pc_q;
    logic [DATA_W-1:0]       ir_q;
    logic                    busy;
    logic                    done;
    logic                    bus_conflict;

    modport master (
        output rin, rout, sin, sout, ba_out, inc_pc, md_read, mem_data_in,
               inport_strobe, inport_data, alu_op, op_start,
        input  bus_data, mar_q, pc_q, ir_q, busy, done, bus_conflict
    );

    modport slave (
        input  rin, rout, sin, sout, ba_out, inc_pc, md_read, mem_data_in,
               inport_strobe, inport_data, alu_op, op_start,
        output bus_data, mar_q, pc_q, ir_q, busy, done, bus_conflict
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative signed multiply (Booth radix-2) / divide (restoring on magnitudes), one bit per cycle.
// Latency DATA_W+1 cycles start->done; start is ignored while busy, no other backpressure.
module muldiv_iter
    import datapath_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  alu_op_t           op,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              busy,
    output logic              done,
    output logic              z_wr,
    output logic [DATA_W-1:0] zhi,
    output logic [DATA_W-1:0] zlo
);
    localparam int CW = $clog2(DATA_W);

    md_state_t         state, state_nxt;
    logic              launch, step;
    logic [CW-1:0]     count;
    logic [DATA_W:0]   acc;
    logic [DATA_W-1:0] qr, mr, a_q;
    logic              q1, is_div, div0, neg_q, neg_r;

    logic [DATA_W:0]   m_ext, booth_sum, rem_sh, trial;

    always_ff @(posedge clock) begin
        if (clear) state <= MD_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (launch) state_nxt = MD_RUN;
            MD_RUN:  if (count == CW'(DATA_W - 1)) state_nxt = MD_DONE;
            MD_DONE: state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_comb begin
        launch = 1'b0;
        step   = 1'b0;
        z_wr   = 1'b0;
        busy   = 1'b0;
        case (state)
            MD_IDLE: launch = start && is_muldiv(op);
            MD_RUN:  begin step = 1'b1; busy = 1'b1; end
            MD_DONE: begin z_wr = 1'b1; busy = 1'b1; end
            default: ;
        endcase
    end

    // acc carries one guard bit so Booth survives the most negative multiplicand
    always_comb begin
        m_ext = {mr[DATA_W-1], mr};
        if (qr[0] && !q1)      booth_sum = acc - m_ext;
        else if (!qr[0] && q1) booth_sum = acc + m_ext;
        else                   booth_sum = acc;
        rem_sh = {acc[DATA_W-1:0], qr[DATA_W-1]};
        trial  = rem_sh - {1'b0, mr};
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            count  <= '0;
            acc    <= '0;
            qr     <= '0;
            mr     <= '0;
            a_q    <= '0;
            q1     <= 1'b0;
            is_div <= 1'b0;
            div0   <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= z_wr;
            if (launch) begin
                count  <= '0;
                acc    <= '0;
                q1     <= 1'b0;
                a_q    <= a_in;
                is_div <= (op == OP_DIV);
                div0   <= (b_in == '0);
                neg_q  <= a_in[DATA_W-1] ^ b_in[DATA_W-1];
                neg_r  <= a_in[DATA_W-1];
                if (op == OP_DIV) begin
                    qr <= a_in[DATA_W-1] ? -a_in : a_in;
                    mr <= b_in[DATA_W-1] ? -b_in : b_in;
                end else begin
                    qr <= b_in;
                    mr <= a_in;
                end
            end else if (step) begin
                count <= count + CW'(1);
                if (is_div) begin
                    if (!trial[DATA_W]) begin
                        acc <= trial;
                        qr  <= {qr[DATA_W-2:0], 1'b1};
                    end else begin
                        acc <= rem_sh;
                        qr  <= {qr[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    acc <= {booth_sum[DATA_W], booth_sum[DATA_W:1]};
                    qr  <= {booth_sum[0], qr[DATA_W-1:1]};
                    q1  <= qr[0];
                end
            end
        end
    end

    always_comb begin
        if (!is_div) begin
            zhi = acc[DATA_W-1:0];
            zlo = qr;
        end else if (div0) begin
            zhi = a_q;
            zlo = '1;
        end else begin
            zhi = neg_r ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
            zlo = neg_q ? -qr : qr;
        end
    end

endmodule

// File: rtl/param_bus_datapath.sv
// Single-bus CPU datapath: registers, priority bus encoder, single-cycle ALU and iterative MUL/DIV.
// Register loads land one cycle after the bus drive; MUL/DIV ignores new starts while busy.
module param_bus_datapath
    import datapath_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int IMM_W    = 19
) (
    input  logic                 clock,
    input  logic                 clear,
    param_bus_datapath_if.slave  io
);
    localparam int NSRC = NUM_REGS + 8;
    localparam int SHW  = $clog2(DATA_W);

    logic [DATA_W-1:0] gpr [NUM_REGS];
    logic [DATA_W-1:0] hi_q, lo_q, y_q, zhi_q, zlo_q, pc_q, mdr_q, mar_q, ir_q, inport_q;
    logic [DATA_W-1:0] sp_val [8];
    logic [DATA_W-1:0] bus, c_val, alu_res;
    logic [NSRC-1:0]   src;
    logic [SHW-1:0]    sh;
    logic              md_busy, md_done, md_z_wr;
    logic [DATA_W-1:0] md_hi, md_lo;

    assign c_val = DATA_W'($signed(ir_q[IMM_W-1:0]));

    always_comb begin
        sp_val[SOUT_HI]     = hi_q;
        sp_val[SOUT_LO]     = lo_q;
        sp_val[SOUT_ZHI]    = zhi_q;
        sp_val[SOUT_ZLO]    = zlo_q;
        sp_val[SOUT_PC]     = pc_q;
        sp_val[SOUT_MDR]    = mdr_q;
        sp_val[SOUT_INPORT] = inport_q;
        sp_val[SOUT_C]      = c_val;
    end

    // scan from the highest index down so the lowest requested source wins (R0 first, C last)
    always_comb begin
        bus = '0;
        for (int i = 7; i >= 0; i--)
            if (io.sout[i]) bus = sp_val[i];
        for (int i = NUM_REGS - 1; i >= 0; i--)
            if (io.rout[i]) bus = (i == 0 && io.ba_out) ? '0 : gpr[i];
    end

    assign src             = {io.sout, io.rout};
    assign io.bus_conflict = |(src & (src - NSRC'(1)));
    assign sh              = bus[SHW-1:0];

    always_comb begin
        case (io.alu_op)
            OP_ADD:  alu_res = y_q + bus;
            OP_SUB:  alu_res = y_q - bus;
            OP_AND:  alu_res = y_q & bus;
            OP_OR:   alu_res = y_q | bus;
            OP_SHR:  alu_res = y_q >> sh;
            OP_SHRA: alu_res = $signed(y_q) >>> sh;
            OP_SHL:  alu_res = y_q << sh;
            OP_ROR:  alu_res = (y_q >> sh) | (y_q << (DATA_W - int'(sh)));
            OP_ROL:  alu_res = (y_q << sh) | (y_q >> (DATA_W - int'(sh)));
            OP_NEG:  alu_res = -bus;
            OP_NOT:  alu_res = ~bus;
            default: alu_res = '0;
        endcase
    end

    muldiv_iter #(.DATA_W(DATA_W)) u_muldiv (
        .clock (clock),
        .clear (clear),
        .start (io.op_start),
        .op    (io.alu_op),
        .a_in  (y_q),
        .b_in  (bus),
        .busy  (md_busy),
        .done  (md_done),
        .z_wr  (md_z_wr),
        .zhi   (md_hi),
        .zlo   (md_lo)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) gpr[i] <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            y_q      <= '0;
            zhi_q    <= '0;
            zlo_q    <= '0;
            pc_q     <= '0;
            mdr_q    <= '0;
            mar_q    <= '0;
            ir_q     <= '0;
            inport_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (io.rin[i]) gpr[i] <= bus;
            if (io.sin[SIN_HI])  hi_q  <= bus;
            if (io.sin[SIN_LO])  lo_q  <= bus;
            if (io.sin[SIN_Y])   y_q   <= bus;
            if (io.sin[SIN_MAR]) mar_q <= bus;
            if (io.sin[SIN_IR])  ir_q  <= bus;
            if (io.sin[SIN_MDR]) mdr_q <= io.md_read ? io.mem_data_in : bus;
            if (io.inport_strobe) inport_q <= io.inport_data;
            if (io.sin[SIN_PC])   pc_q <= bus;
            else if (io.inc_pc)   pc_q <= pc_q + DATA_W'(1);
            // Z belongs to the MUL/DIV unit for its whole run
            if (md_z_wr) begin
                zhi_q <= md_hi;
                zlo_q <= md_lo;
            end else if (io.sin[SIN_Z] && !md_busy && !is_muldiv(io.alu_op)) begin
                zhi_q <= '0;
                zlo_q <= alu_res;
            end
        end
    end

    assign io.bus_data = bus;
    assign io.mar_q    = mar_q;
    assign io.pc_q     = pc_q;
    assign io.ir_q     = ir_q;
    assign io.busy     = md_busy;
    assign io.done     = md_done;

endmodule
